// File: rtl/i2c_wb_slave.sv
// i2c_wb_slave: 7-bit-address I2C slave with an 8-bit Wishbone classic register port.
// Define I2C_CLK_STRETCH_EN to stretch SCL instead of NACKing on overrun / sending 0xFF on underrun.
module i2c_wb_slave (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] wb_add_i,
  input  logic [7:0] wb_data_i,
  output logic [7:0] wb_data_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       irq,
  output logic       trans_comp
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT} state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_last_q, sda_last_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] sadr_q, sadr_d;
  logic       en_q, en_d, ien_q, ien_d;
  logic       rxf_q, rxf_d, txe_q, txe_d, busy_q, busy_d, rw_q, rw_d;
  logic       iflag_q, iflag_d, ovr_q, ovr_d;
  logic [7:0] rxdata_q, rxdata_d, txdata_q, txdata_d;
  logic       sda_oe_q, sda_oe_d, stretch_q, stretch_d;
  logic       tc_q, tc_d, ack_q, ack_d;
  logic [7:0] dat_q, dat_d, rd_mux_s;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, wb_req_s, load_s;
  logic       unused_s;

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise_s = scl_s & ~scl_last_q;
  assign scl_fall_s = ~scl_s & scl_last_q;
  assign start_s    = sda_last_q & ~sda_s & scl_s & scl_last_q;
  assign stop_s     = ~sda_last_q & sda_s & scl_s & scl_last_q;
  assign wb_req_s   = wb_stb_i & wb_cyc_i & ~ack_q;
  assign unused_s   = ^wb_add_i[7:3];

  always_comb begin
    rd_mux_s = 8'h00;
    case (wb_add_i[2:0])
      3'd0:    rd_mux_s = {1'b0, sadr_q};
      3'd1:    rd_mux_s = {6'd0, ien_q, en_q};
      3'd2:    rd_mux_s = {2'd0, ovr_q, iflag_q, rw_q, busy_q, txe_q, rxf_q};
      3'd3:    rd_mux_s = rxdata_q;
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Host accesses are applied first so that any hardware flag set below overrides them.
  always_comb begin
    state_d = state_q;   bit_cnt_d = bit_cnt_q; shift_d = shift_q;
    sadr_d = sadr_q;     en_d = en_q;           ien_d = ien_q;
    rxf_d = rxf_q;       txe_d = txe_q;         busy_d = busy_q;   rw_d = rw_q;
    iflag_d = iflag_q;   ovr_d = ovr_q;         rxdata_d = rxdata_q; txdata_d = txdata_q;
    sda_oe_d = sda_oe_q; stretch_d = stretch_q; tc_d = 1'b0;
    ack_d = wb_req_s;    dat_d = 8'h00;         load_s = 1'b0;

    if (wb_req_s) begin
      if (wb_we_i) begin
        case (wb_add_i[2:0])
          3'd0: sadr_d = wb_data_i[6:0];
          3'd1: begin en_d = wb_data_i[0]; ien_d = wb_data_i[1]; end
          3'd2: begin
            if (wb_data_i[4]) iflag_d = 1'b0; else iflag_d = iflag_q;
            if (wb_data_i[5]) ovr_d = 1'b0; else ovr_d = ovr_q;
          end
          3'd4: begin txdata_d = wb_data_i; txe_d = 1'b0; end
          default: dat_d = 8'h00;
        endcase
      end else begin
        dat_d = rd_mux_s;
        if (wb_add_i[2:0] == 3'd3) rxf_d = 1'b0; else rxf_d = rxf_q;
      end
    end else begin
      dat_d = 8'h00;
    end

    case (state_q)
      ADDR: begin
        if (scl_rise_s) begin
          shift_d = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
          if (en_q && shift_q[7:1] == sadr_q) begin
            sda_oe_d = 1'b0; busy_d = 1'b1; rw_d = shift_q[0]; state_d = ADDR_ACK;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = ADDR;
        end
      end
      ADDR_ACK: begin
        if (scl_fall_s) begin
          bit_cnt_d = 4'd0;
          sda_oe_d = 1'b1;
          if (rw_q) begin state_d = TX; load_s = 1'b1; end
          else state_d = RX;
        end else begin
          state_d = ADDR_ACK;
        end
      end
      RX: begin
        if (stretch_q) begin
          if (!rxf_q) begin
            rxdata_d = shift_q; rxf_d = 1'b1; iflag_d = 1'b1;
            sda_oe_d = 1'b0; stretch_d = 1'b0; state_d = RX_ACK;
          end else begin
            state_d = RX;
          end
        end else if (scl_rise_s) begin
          shift_d = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
          if (!rxf_q) begin
            rxdata_d = shift_q; rxf_d = 1'b1; iflag_d = 1'b1; sda_oe_d = 1'b0; state_d = RX_ACK;
          end else begin
`ifdef I2C_CLK_STRETCH_EN
            stretch_d = 1'b1;
`else
            ovr_d = 1'b1; iflag_d = 1'b1; sda_oe_d = 1'b1; state_d = RX_ACK;
`endif
          end
        end else begin
          state_d = RX;
        end
      end
      RX_ACK: begin
        if (scl_fall_s) begin
          sda_oe_d = 1'b1; bit_cnt_d = 4'd0; state_d = RX;
        end else begin
          state_d = RX_ACK;
        end
      end
      TX: begin
        if (stretch_q) begin
          load_s = 1'b1;
        end else if (scl_rise_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1; state_d = TX_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b1};
            sda_oe_d = shift_q[6];
          end
        end else begin
          state_d = TX;
        end
      end
      TX_ACK: begin
        if (scl_rise_s && sda_s) begin
          state_d = WAIT;
        end else if (scl_fall_s) begin
          bit_cnt_d = 4'd0; state_d = TX; load_s = 1'b1;
        end else begin
          state_d = TX_ACK;
        end
      end
      default: state_d = state_q;
    endcase

    // The shifter is loaded at the SCL fall that ends an ACK bit, or when a stretch resolves.
    if (load_s) begin
      if (!txe_q) begin
        shift_d = txdata_q; sda_oe_d = txdata_q[7]; txe_d = 1'b1; iflag_d = 1'b1; stretch_d = 1'b0;
      end else begin
`ifdef I2C_CLK_STRETCH_EN
        stretch_d = 1'b1; sda_oe_d = 1'b1;
`else
        shift_d = 8'hFF; sda_oe_d = 1'b1; ovr_d = 1'b1; txe_d = 1'b1; iflag_d = 1'b1;
`endif
      end
    end else begin
      load_s = 1'b0;
    end

    if (stop_s) begin
      state_d = IDLE; sda_oe_d = 1'b1; stretch_d = 1'b0;
      if (busy_q) begin busy_d = 1'b0; iflag_d = 1'b1; tc_d = 1'b1; end
      else busy_d = 1'b0;
    end else if (start_s) begin
      state_d = ADDR; bit_cnt_d = 4'd0; sda_oe_d = 1'b1; stretch_d = 1'b0;
    end else begin
      tc_d = 1'b0;
    end
  end

  // State, registers and line synchronizers; reset releases both lines on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;       scl_sync_q <= 2'b11;  sda_sync_q <= 2'b11;
      scl_last_q <= 1'b1;    sda_last_q <= 1'b1;   bit_cnt_q <= 4'd0;
      shift_q <= 8'h00;      sadr_q <= 7'h00;      en_q <= 1'b0;     ien_q <= 1'b0;
      rxf_q <= 1'b0;         txe_q <= 1'b1;        busy_q <= 1'b0;   rw_q <= 1'b0;
      iflag_q <= 1'b0;       ovr_q <= 1'b0;        rxdata_q <= 8'h00; txdata_q <= 8'h00;
      sda_oe_q <= 1'b1;      stretch_q <= 1'b0;    tc_q <= 1'b0;
      ack_q <= 1'b0;         dat_q <= 8'h00;
    end else begin
      state_q <= state_d;    scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_last_q <= scl_s;   sda_last_q <= sda_s;  bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;    sadr_q <= sadr_d;     en_q <= en_d;     ien_q <= ien_d;
      rxf_q <= rxf_d;        txe_q <= txe_d;       busy_q <= busy_d; rw_q <= rw_d;
      iflag_q <= iflag_d;    ovr_q <= ovr_d;       rxdata_q <= rxdata_d; txdata_q <= txdata_d;
      sda_oe_q <= sda_oe_d;  stretch_q <= stretch_d; tc_q <= tc_d;
      ack_q <= ack_d;        dat_q <= dat_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_data_o  = dat_q;
  assign scl_o      = 1'b0;
  assign sda_o      = 1'b0;
  assign sda_oe     = sda_oe_q;
`ifdef I2C_CLK_STRETCH_EN
  assign scl_oe     = ~stretch_q;
`else
  assign scl_oe     = 1'b1;
`endif
  assign irq        = iflag_q & ien_q;
  assign trans_comp = tc_q;
endmodule

// File: tb/tb_i2c_wb_slave.sv
// Directed bench for i2c_wb_slave: a bit-banged I2C master plus Wishbone register accesses.
module tb_i2c_wb_slave;
  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] wb_add_i = 8'h00, wb_data_i = 8'h00, wb_data_o;
  logic       wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_o, sda_o, scl_oe, sda_oe, irq, trans_comp;
  wire        scl_in = scl_m & scl_oe;
  wire        sda_in = sda_m & sda_oe;
  int         pass_cnt = 0, total_cnt = 0, tc_cnt = 0, tc_base;
  logic       ack;
  logic [7:0] q;

  i2c_wb_slave dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_add_i(wb_add_i), .wb_data_i(wb_data_i),
    .wb_data_o(wb_data_o), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .scl_in(scl_in), .sda_in(sda_in), .scl_o(scl_o), .sda_o(sda_o),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .irq(irq), .trans_comp(trans_comp)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) if (trans_comp) tc_cnt <= tc_cnt + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_access(input logic [7:0] a, input logic we, input logic [7:0] d,
                           output logic [7:0] r);
    @(negedge wb_clk_i);
    wb_add_i = a; wb_we_i = we; wb_data_i = d; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("wb_ack_rise", wb_ack_o, 1'b1);
    r = wb_data_o;
    @(negedge wb_clk_i);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("wb_ack_one_cycle", wb_ack_o, 1'b0);
    check("wb_data_idle", wb_data_o, 8'h00);
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    wb_access(a, 1'b1, d, r);
  endtask

  task automatic wb_rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] r;
    wb_access(a, 1'b0, 8'h00, r);
    check(tag, r, exp);
  endtask

  task automatic set_sda(input logic v);
    wait_cyc(2);
    sda_m = v;
    wait_cyc(6);
  endtask

  // One SCL high phase; waits (bounded) for a stretching slave to release SCL.
  task automatic clk_high(output logic b);
    int n;
    scl_m = 1'b1;
    n = 0;
    #1;
    while (scl_in !== 1'b1 && n < 5000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (n >= 5000) check("scl_release_timeout", scl_in, 1'b1);
    wait_cyc(4);
    b = sda_in;
    wait_cyc(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(8);
    scl_m = 1'b1; wait_cyc(8);
    sda_m = 1'b0; wait_cyc(8);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(2);
    sda_m = 1'b0; wait_cyc(6);
    scl_m = 1'b1; wait_cyc(8);
    sda_m = 1'b1; wait_cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic a);
    logic [7:0] seen;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      set_sda(d[i]);
      clk_high(b);
      seen[i] = b;
    end
    check("wr_bits_on_line", seen, d);
    set_sda(1'b1);
    clk_high(a);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      set_sda(1'b1);
      clk_high(b);
      d[i] = b;
    end
    set_sda(nack);
    clk_high(b);
    check("master_ack_on_line", b, nack);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_data", wb_data_o, 8'h00);
    check("rst_sda_oe", sda_oe, 1'b1);
    check("rst_scl_oe", scl_oe, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_trans_comp", trans_comp, 1'b0);
    check("pad_outs_zero", {scl_o, sda_o}, 8'h00);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    wait_cyc(2);

    wb_rd(8'h00, 8'h00, "rst_sadr");
    wb_rd(8'h01, 8'h00, "rst_ctrl");
    wb_rd(8'h02, 8'h02, "rst_stat");
    wb_rd(8'h03, 8'h00, "rst_rxdata");
    wb_rd(8'h05, 8'h00, "unmapped_read");

    wb_wr(8'h00, 8'h50);
    wb_wr(8'h01, 8'h03);
    wb_wr(8'h05, 8'hFF);
    wb_rd(8'h00, 8'h50, "sadr_rb");
    wb_rd(8'h01, 8'h03, "ctrl_rb");

    // Master write of one byte
    tc_base = tc_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
    send_byte(8'h5A, ack); check("wr_data_ack", ack, 1'b0);
    wb_rd(8'h02, 8'h17, "wr_stat_busy");
    check("wr_irq", irq, 1'b1);
    i2c_stop();
    check("wr_trans_comp", tc_cnt - tc_base, 8'd1);
    wb_rd(8'h03, 8'h5A, "wr_rxdata");
    wb_rd(8'h02, 8'h12, "wr_stat_after");
    wb_wr(8'h02, 8'h10);
    wb_rd(8'h02, 8'h02, "w1c_if");
    check("irq_cleared", irq, 1'b0);

    // Address mismatch
    tc_base = tc_cnt;
    i2c_start();
    send_byte(8'hA2, ack); check("nomatch_nack", ack, 1'b1);
    check("nomatch_sda_released", sda_oe, 1'b1);
    i2c_stop();
    check("nomatch_no_tc", tc_cnt - tc_base, 8'd0);
    wb_rd(8'h02, 8'h02, "nomatch_stat");

    // Master read of 0xC3, then NACK
    wb_wr(8'h04, 8'hC3);
    wb_rd(8'h02, 8'h00, "txdata_clears_txe");
    tc_base = tc_cnt;
    i2c_start();
    send_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b0);
    recv_byte(1'b1, q);
    check("rd_data", q, 8'hC3);
    wb_rd(8'h02, 8'h1E, "rd_stat");
    check("rd_wait_sda_released", sda_oe, 1'b1);
    i2c_stop();
    check("rd_trans_comp", tc_cnt - tc_base, 8'd1);
    wb_rd(8'h02, 8'h1A, "rd_stat_after");
    wb_wr(8'h02, 8'h10);
    wb_rd(8'h02, 8'h0A, "rd_w1c");

    // Two bytes without draining RXDATA
    i2c_start();
    send_byte(8'hA0, ack); check("ovr_addr_ack", ack, 1'b0);
    send_byte(8'h11, ack); check("ovr_first_ack", ack, 1'b0);
`ifdef I2C_CLK_STRETCH_EN
    fork
      send_byte(8'h22, ack);
      begin
        wait_cyc(200);
        check("stretch_scl_low", scl_in, 1'b0);
        wb_rd(8'h03, 8'h11, "stretch_first_byte");
      end
    join
    check("stretch_second_ack", ack, 1'b0);
    wb_rd(8'h02, 8'h17, "stretch_stat");
    i2c_stop();
    wb_rd(8'h03, 8'h22, "stretch_second_byte");
    wb_wr(8'h02, 8'h10);
`else
    send_byte(8'h22, ack); check("ovr_second_nack", ack, 1'b1);
    wb_rd(8'h02, 8'h37, "ovr_stat");
    i2c_stop();
    wb_rd(8'h03, 8'h11, "ovr_rxdata_kept");
    wb_rd(8'h02, 8'h32, "ovr_stat_after");
    wb_wr(8'h02, 8'h30);
`endif
    wb_rd(8'h02, 8'h02, "ovr_cleared");

    // Reset during the fourth data bit of a write
    i2c_start();
    send_byte(8'hA0, ack); check("rst_addr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_sda(1'b0);
      clk_high(ack);
    end
    set_sda(1'b1);
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("midrst_sda_oe", sda_oe, 1'b1);
    check("midrst_scl_oe", scl_oe, 1'b1);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    wb_rd(8'h00, 8'h00, "midrst_sadr");
    wb_rd(8'h02, 8'h02, "midrst_stat");
    scl_m = 1'b1; wait_cyc(8);
    wb_wr(8'h00, 8'h50);
    wb_wr(8'h01, 8'h03);
    tc_base = tc_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("post_rst_addr_ack", ack, 1'b0);
    send_byte(8'h77, ack); check("post_rst_data_ack", ack, 1'b0);
    i2c_stop();
    check("post_rst_tc", tc_cnt - tc_base, 8'd1);
    wb_rd(8'h03, 8'h77, "post_rst_rxdata");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_wb_slave.md
# i2c_wb_slave

Seven-bit-address I2C slave controller with an 8-bit Wishbone classic register port. It sits between the system Wishbone bus and open-drain SCL/SDA pads; the pad logic ANDs the active-low enables with other bus agents and pull-ups. Software programs the slave address, drains received bytes, supplies transmit bytes and is notified through `irq` and `trans_comp`.

## Interface
- No parameters.
- `wb_clk_i` in 1: single system clock; all logic on its rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wb_add_i` in 8: register address; only bits [2:0] are decoded.
- `wb_data_i` in 8: write data.
- `wb_data_o` out 8: read data; valid while `wb_ack_o`=1; 0x00 otherwise.
- `wb_we_i` in 1: 1=write, 0=read.
- `wb_stb_i`, `wb_cyc_i` in 1: Wishbone strobe and cycle.
- `wb_ack_o` out 1: transfer acknowledge.
- `scl_in`, `sda_in` in 1: bus line levels.
- `scl_o`, `sda_o` out 1: constant 0 (open-drain data).
- `scl_oe`, `sda_oe` out 1: active-low enable; 0 pulls the line low, 1 releases it.
- `irq` out 1: `IF & IEN`.
- `trans_comp` out 1: one-cycle pulse at STOP ending an addressed transaction.

## Operation
- Registers:
  - 0x0 SADR (rw): [6:0] slave address; reset 0x00.
  - 0x1 CTRL (rw): bit0 EN, bit1 IEN; reset 0x00.
  - 0x2 STAT (r; write-1-to-clear bits 4,5): bit0 RXF, bit1 TXE (reset 1), bit2 BUSY, bit3 RW, bit4 IF, bit5 OVR.
  - 0x3 RXDATA (r): last received byte; a read clears RXF.
  - 0x4 TXDATA (w): next byte to send; a write clears TXE.
  - Other addresses read 0x00 and ignore writes; all accesses are acknowledged.
- Line inputs pass through 2-flop synchronizers, then edge detection.
- START: SDA falls while SCL is high. It is accepted from any state (repeated START) and enters ADDR.
- STOP: SDA rises while SCL is high. It enters IDLE from any state.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
- Data is sampled on SCL rising and driven on SCL falling, MSB first.
- ADDR: shift in 8 bits.
  - Match when EN=1 and bits[7:1]=SADR. On match, pull SDA low for the 9th bit, set BUSY, and latch RW=bit0.
  - No match → WAIT with lines released.
- RX (RW=0):
  - After 8 bits, if RXF=0: store the byte in RXDATA, set RXF and IF, ACK.
  - If RXF=1: set OVR and IF, NACK, discard the byte.
  - Then return to RX.
- TX (RW=1):
  - At the SCL fall ending the ACK bit, load TXDATA into the shifter.
  - If TXE=1 at load time (underrun), send 0xFF and set OVR.
  - After the load, set TXE and IF, then shift out 8 bits with SDA released for 1s.
  - TX_ACK samples the master bit: ACK → TX; NACK → WAIT.
- WAIT: all lines released until START or STOP.
- At STOP after a matched address: clear BUSY, set IF, pulse `trans_comp`.

## Timing
- Wishbone: `wb_ack_o` rises the cycle after `stb&cyc` and lasts exactly one cycle (registered `stb&cyc&!ack`). Writes take effect on that edge. Read data is registered alongside the ack.
- Line-to-action latency: 3 cycles from a pin edge (2 sync + 1 edge register).
- Each SCL high and low phase must last ≥3 `wb_clk_i` cycles.
- A host RXDATA-read and an I2C byte store in the same cycle: the store wins and RXF stays 1.
- A host W1C and a hardware flag set in the same cycle: the set wins.
- Reset values: `wb_ack_o`=0, `wb_data_o`=0, `scl_oe`=`sda_oe`=1, `irq`=0, `trans_comp`=0, FSM=IDLE.
- Reset mid-transfer releases both lines on the next edge and the slave ignores the bus until the next START.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - In RX, a byte arriving while RXF=1 is not NACKed. Instead, `scl_oe` is held 0 from the SCL fall after bit 8 until RXDATA is read, then the byte is ACKed.
  - In TX, if TXE=1 at load time, `scl_oe` is held 0 until TXDATA is written. No underrun occurs.
- `I2C_CLK_STRETCH_EN` not defined: `scl_oe` is constant 1, and the overrun/underrun behaviour in Operation applies.

## Test plan
- Reset, then read all registers → SADR=0x00, CTRL=0x00, STAT=0x02. Every access acks exactly one cycle after strobe.
- SADR=0x50, CTRL=0x03. Master writes address 0xA0 then byte 0x5A → ACK after both. RXDATA=0x5A, RXF=1, `irq`=1. STOP gives one `trans_comp` pulse.
- Master sends address 0xA2 → address not ACKed (`sda_oe` stays 1). No flags set, no `trans_comp`.
- TXDATA=0xC3, master reads with 0xA1 → bits 11000011 appear on SDA. Master NACK → WAIT. TXE=1, RW=1.
- Two written bytes with no RXDATA read → second byte NACKed, OVR=1 (stretch off). With `I2C_CLK_STRETCH_EN`, SCL is held low until RXDATA is read, then ACK.
- Assert `wb_rst_i` during RX bit 4 → both lines released next cycle. The next START+0xA0 transaction is accepted normally after SADR and CTRL are reprogrammed.
